led_pong_engine: RTL

//  Game core of the LED Pong build. One lit LED (the ball) bounces across an

---
 rtl/led_pong_engine.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/led_pong_engine.sv
// LED Pong game core: bounces one lit LED between two paddles,
// keeps score and flashes the bar after each missed return.
module led_pong_engine #(
    parameter int WIDTH       = 8,
    parameter int WIN_SCORE   = 7,
    parameter int FLASH_TICKS = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Tick,
    input  logic             Begin,
    input  logic             HitL,
    input  logic             HitR,
    output logic [WIDTH-1:0] Out,
    output logic [3:0]       ScoreL,
    output logic [3:0]       ScoreR,
    output logic             GameOver
);

    localparam int PW = $clog2(WIDTH);
    localparam int FW = $clog2(FLASH_TICKS + 1);
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
    localparam logic [PW-1:0] NEAR_R = PW'(WIDTH - 2);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LO_HALF = ONES >> (WIDTH - WIDTH / 2);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_MOVE,
        S_MISS,
        S_OVER
    } state_t;

    state_t            r_state, w_state;
    logic [PW-1:0]     r_pos, w_pos;
    logic              r_dir, w_dir;       // 1 = moving right
    logic              r_server, w_server; // 1 = right player serves
    logic              r_hit_l, w_hit_l;
    logic              r_hit_r, w_hit_r;
    logic [FW-1:0]     r_flash, w_flash;
    logic              r_begin_d;
    logic [WIDTH-1:0]  r_out, w_out;
    logic [3:0]        r_score_l, w_score_l;
    logic [3:0]        r_score_r, w_score_r;
    logic              r_over, w_over;
    logic              w_rise;
    logic              w_at_r;
    logic              w_at_l;
    logic [3:0]        w_scorer_pts;

    assign w_rise = Begin & ~r_begin_d;
    assign w_at_r = (r_pos == LAST) && r_dir;
    assign w_at_l = (r_pos == '0) && !r_dir;
    assign w_scorer_pts = r_server ? r_score_l : r_score_r;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state   <= S_IDLE;
            r_pos     <= '0;
            r_dir     <= 1'b1;
            r_server  <= 1'b0;
            r_hit_l   <= 1'b0;
            r_hit_r   <= 1'b0;
            r_flash   <= '0;
            r_begin_d <= 1'b0;
            r_out     <= '0;
            r_score_l <= '0;
            r_score_r <= '0;
            r_over    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_pos     <= w_pos;
            r_dir     <= w_dir;
            r_server  <= w_server;
            r_hit_l   <= w_hit_l;
            r_hit_r   <= w_hit_r;
            r_flash   <= w_flash;
            r_begin_d <= Begin;
            r_out     <= w_out;
            r_score_l <= w_score_l;
            r_score_r <= w_score_r;
            r_over    <= w_over;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_pos     = r_pos;
        w_dir     = r_dir;
        w_server  = r_server;
        w_hit_l   = r_hit_l;
        w_hit_r   = r_hit_r;
        w_flash   = r_flash;
        w_out     = r_out;
        w_score_l = r_score_l;
        w_score_r = r_score_r;
        w_over    = r_over;
        unique case (r_state)
            S_SERVE: begin
                if (Tick) begin
                    w_state = S_MOVE;
                    w_pos   = r_dir ? r_pos + 1'b1 : r_pos - 1'b1;
                    w_out   = ONE << w_pos;
                end
            end
            S_MOVE: begin
                if (Tick) begin
                    w_hit_l = 1'b0;
                    w_hit_r = 1'b0;
                    if (w_at_r || w_at_l) begin
                        if (w_at_r ? (r_hit_r | HitR) : (r_hit_l | HitL)) begin
                            w_dir = ~r_dir;
                            w_pos = w_at_r ? NEAR_R : PW'(1);
                            w_out = ONE << w_pos;
                        end else begin
                            w_state   = S_MISS;
                            w_out     = ONES;
                            w_flash   = '0;
                            w_server  = w_at_r;
                            w_score_l = r_score_l + {3'b0, w_at_r};
                            w_score_r = r_score_r + {3'b0, w_at_l};
                        end
                    end else begin
                        w_pos = r_dir ? r_pos + 1'b1 : r_pos - 1'b1;
                        w_out = ONE << w_pos;
                    end
                end else begin
                    if (HitR && w_at_r) w_hit_r = 1'b1;
                    if (HitL && w_at_l) w_hit_l = 1'b1;
                end
            end
            S_MISS: begin
                if (Tick) begin
                    if (r_flash == FLASH_LAST) begin
                        w_flash = '0;
                        if (w_scorer_pts == WIN) begin
                            w_state = S_OVER;
                            w_over  = 1'b1;
                            w_out   = r_server ? LO_HALF : ~LO_HALF;
                        end else begin
                            w_state = S_SERVE;
                            w_pos   = r_server ? LAST : '0;
                            w_dir   = ~r_server;
                            w_out   = ONE << w_pos;
                        end
                    end else begin
                        w_flash = r_flash + 1'b1;
                        w_out   = ~r_out;
                    end
                end
            end
            default: ;
        endcase
        // Only IDLE and GAMEOVER accept a new game.
        if (w_rise && (r_state == S_IDLE || r_state == S_OVER)) begin
            w_state   = S_SERVE;
            w_pos     = '0;
            w_dir     = 1'b1;
            w_server  = 1'b0;
            w_hit_l   = 1'b0;
            w_hit_r   = 1'b0;
            w_flash   = '0;
            w_out     = ONE;
            w_score_l = '0;
            w_score_r = '0;
            w_over    = 1'b0;
        end
    end

    assign Out      = r_out;
    assign ScoreL   = r_score_l;
    assign ScoreR   = r_score_r;
    assign GameOver = r_over;

endmodule
